// File: rtl/ad7476_spi_rx_if.sv
// ad7476_spi_rx_if
//   Bundles the capture engine's control handshake, ADC pins and result bus.
//   slave  : the capture engine (drives done/busy/ADC pins/sample).
//   master : the sequencing FSM / ADC side (drives start, rden, sdata).
//   spi_start_i     1-cycle start request
//   spi_rden_i      read enable, held for the transfer
//   spi_tfer_done_o 1-cycle end-of-frame pulse
//   busy_o          engine not idle
//   adc_cs_n_o      ADC chip select (active low)
//   adc_sclk_o      ADC serial clock (idles high)
//   adc_sdata_i     ADC serial data
//   sample_o        last captured 12-bit result
//   sample_valid_o  1-cycle pulse when sample_o updates
//   frame_err_o     sticky leading-zero error flag
interface ad7476_spi_rx_if;
    logic        spi_start_i;
    logic        spi_rden_i;
    logic        spi_tfer_done_o;
    logic        busy_o;
    logic        adc_cs_n_o;
    logic        adc_sclk_o;
    logic        adc_sdata_i;
    logic [11:0] sample_o;
    logic        sample_valid_o;
    logic        frame_err_o;

    modport slave (
        input  spi_start_i, spi_rden_i, adc_sdata_i,
        output spi_tfer_done_o, busy_o, adc_cs_n_o, adc_sclk_o,
               sample_o, sample_valid_o, frame_err_o
    );

    modport master (
        output spi_start_i, spi_rden_i, adc_sdata_i,
        input  spi_tfer_done_o, busy_o, adc_cs_n_o, adc_sclk_o,
               sample_o, sample_valid_o, frame_err_o
    );
endinterface

// File: rtl/ad7476_spi_rx.sv
// ad7476_spi_rx
//   Serial capture engine for the AD7476: drops CS_n, clocks out 16 SCLK
//   periods, shifts the frame in MSB first and hands back the 12-bit result.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   bus    : ad7476_spi_rx_if.slave (handshake, ADC pins, result)
//   CLK_DIV      : SCLK half-period in clk_i cycles (2..255)
//   QUIET_CYCLES : CS_n-high time after the frame before done (1..255)
module ad7476_spi_rx #(
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ad7476_spi_rx_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_QUIET,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_div_cnt;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_shift;
    logic        r_sdata;
    logic        r_cs_n;
    logic        r_sclk;
    logic        r_done;
    logic        r_busy;
    logic [11:0] r_sample;
    logic        r_valid;
    logic        r_err;

    logic w_div_end;
    logic w_quiet_end;

    assign w_div_end   = (r_div_cnt == DIV_LAST);
    assign w_quiet_end = (r_div_cnt == QUIET_LAST);

    // Serial data is registered once so the capture uses a value that has
    // been stable for CLK_DIV-1 cycles after the preceding SCLK fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_sdata <= 1'b0;
        else       r_sdata <= bus.adc_sdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.spi_start_i) begin
                        r_state   <= S_SETUP;
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_div_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_state   <= S_SHIFT;
                        r_sclk    <= 1'b0;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end else begin
                        r_div_cnt <= '0;
                        if (!r_sclk) begin
                            // Rising edge: capture in the same cycle SCLK goes high.
                            r_sclk    <= 1'b1;
                            r_shift   <= {r_shift[14:0], r_sdata};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end else if (r_bit_cnt == 5'd16) begin
                            // End of the 16th high phase: SCLK stays high.
                            r_cs_n  <= 1'b1;
                            r_state <= S_QUIET;
                        end else begin
                            r_sclk <= 1'b0;
                        end
                    end
                end
                S_QUIET: begin
                    if (w_quiet_end) begin
                        // Outputs are registered, so the DONE-cycle pulses are
                        // loaded on the way in.
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        if (bus.spi_rden_i) begin
                            r_sample <= r_shift[11:0];
                            r_valid  <= 1'b1;
                        end
                        if (r_shift[15:12] != 4'd0) r_err <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.spi_tfer_done_o = r_done;
    assign bus.busy_o          = r_busy;
    assign bus.adc_cs_n_o      = r_cs_n;
    assign bus.adc_sclk_o      = r_sclk;
    assign bus.sample_o        = r_sample;
    assign bus.sample_valid_o  = r_valid;
    assign bus.frame_err_o     = r_err;

endmodule

// File: tb/tb_ad7476_spi_rx.sv
// tb_ad7476_spi_rx
//   Randomized bench for ad7476_spi_rx. The reference model describes each
//   output as a function of the cycle offset from the accepted start, plus a
//   few hand-computed expectations for the default parameters.
module tb_ad7476_spi_rx;

    localparam int CD = 2;
    localparam int Q  = 4;
    localparam int T  = 33 * CD + Q + 1;   // done cycle (71 with defaults)
    localparam int IDLE_ST = -1000000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    ad7476_spi_rx_if bus();

    ad7476_spi_rx #(.CLK_DIV(CD), .QUIET_CYCLES(Q)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nmis = 0;

    // model state
    int          e  = 0;          // edge counter
    int          st = IDLE_ST;    // edge index at which the active start was taken
    logic [15:0] adc_word = '0;
    logic [15:0] mword    = '0;
    logic [11:0] msample  = '0;
    logic        merr     = 1'b0;

    // observation counters
    int   ndone = 0;
    int   nvalid = 0;
    int   nrise = 0;
    int   last_done_t = -1;
    logic prev_sclk = 1'b1;

    // ADC: the k-th SCLK fall presents frame bit 15-(k-1); CS fall rewinds.
    int ak = 0;
    initial begin
        bus.adc_sdata_i = 1'b0;
        forever begin
            @(negedge bus.adc_sclk_o or negedge bus.adc_cs_n_o);
            if (bus.adc_sclk_o) begin
                ak = 0;
            end else if (ak < 16) begin
                bus.adc_sdata_i = adc_word[4'(15 - ak)];
                ak++;
            end
        end
    end

    // Reference model: tracks which start is accepted and what DONE delivers.
    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                st      = IDLE_ST;
                msample = '0;
                merr    = 1'b0;
            end else begin
                if (bus.spi_start_i && (e - st) > T) begin
                    st    = e;
                    mword = adc_word;
                end
                e = e + 1;
                if ((e - st) == T) begin
                    if (bus.spi_rden_i) msample = mword[11:0];
                    if (mword[15:12] != 4'd0) merr = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    int          c_t;
    logic        c_act;
    logic        x_sclk;
    logic [17:0] c_exp;
    logic [17:0] c_got;
    initial begin
        forever begin
            @(negedge clk_i);
            c_t   = e - st;
            c_act = (c_t >= 1) && (c_t <= T);
            if (c_act && c_t >= CD + 1 && c_t <= 33 * CD)
                x_sclk = (((c_t - CD - 1) / CD) % 2) == 1;
            else
                x_sclk = 1'b1;
            c_exp = {c_act,
                     !(c_act && c_t <= 33 * CD),
                     x_sclk,
                     c_act && c_t == T,
                     c_act && c_t == T && bus.spi_rden_i,
                     merr,
                     msample};
            c_got = {bus.busy_o, bus.adc_cs_n_o, bus.adc_sclk_o, bus.spi_tfer_done_o,
                     bus.sample_valid_o, bus.frame_err_o, bus.sample_o};
            nvec++;
            if (c_got !== c_exp) begin
                nmis++;
                $display("FAIL cycle_cmp t=%0d {busy,cs_n,sclk,done,valid,err,sample} got=%h want=%h",
                         c_t, c_got, c_exp);
            end
            if (bus.spi_tfer_done_o) begin
                ndone++;
                last_done_t = c_t;
            end
            if (bus.sample_valid_o) nvalid++;
            if (bus.adc_sclk_o && !prev_sclk) nrise++;
            prev_sclk = bus.adc_sclk_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic start_frame(input logic [15:0] w);
        adc_word = w;
        bus.spi_start_i = 1'b1;
        tick();
        bus.spi_start_i = 1'b0;
    endtask

    task automatic pulse_start();
        bus.spi_start_i = 1'b1;
        tick();
        bus.spi_start_i = 1'b0;
    endtask

    task automatic wait_t(input int tc);
        int n;
        n = 0;
        while ((e - st) < tc && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            nvec++;
            nmis++;
            $display("FAIL wait_timeout: got t=%0d want t=%0d", e - st, tc);
        end
    endtask

    int d0, v0, r0, old_st;
    logic [15:0] w;

    initial begin
        bus.spi_start_i = 1'b0;
        bus.spi_rden_i  = 1'b0;
        #1 rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;

        // reset / idle
        repeat (10) tick();
        check("idle_cs_n",   32'(bus.adc_cs_n_o), 32'd1);
        check("idle_sclk",   32'(bus.adc_sclk_o), 32'd1);
        check("idle_done",   32'(ndone), 32'd0);
        check("idle_sample", 32'(bus.sample_o), 32'd0);
        check("idle_busy",   32'(bus.busy_o), 32'd0);

        // frame 0x0A5C, rden=1
        bus.spi_rden_i = 1'b1;
        d0 = ndone; v0 = nvalid; r0 = nrise;
        start_frame(16'h0A5C);
        wait_t(T + 1);
        check("a5c_rises",   32'(nrise - r0), 32'd16);
        check("a5c_done_n",  32'(ndone - d0), 32'd1);
        check("a5c_valid_n", 32'(nvalid - v0), 32'd1);
        check("a5c_done_t",  32'(last_done_t), 32'd71);
        check("a5c_sample",  32'(bus.sample_o), 32'h0A5C);
        check("a5c_err",     32'(bus.frame_err_o), 32'd0);

        // bad leading zeros, then a clean frame
        start_frame(16'h8FFF);
        wait_t(T + 1);
        check("8fff_sample", 32'(bus.sample_o), 32'h0FFF);
        check("8fff_err",    32'(bus.frame_err_o), 32'd1);
        start_frame(16'h0001);
        wait_t(T + 1);
        check("0001_sample", 32'(bus.sample_o), 32'h001);
        check("0001_err",    32'(bus.frame_err_o), 32'd1);

        // rden=0
        bus.spi_rden_i = 1'b0;
        d0 = ndone; v0 = nvalid;
        start_frame(16'h0123);
        wait_t(T + 1);
        check("nord_done_n",  32'(ndone - d0), 32'd1);
        check("nord_done_t",  32'(last_done_t), 32'd71);
        check("nord_valid_n", 32'(nvalid - v0), 32'd0);
        check("nord_sample",  32'(bus.sample_o), 32'h001);

        // extra starts at 5, 40, 71 ignored; start at 72 accepted
        bus.spi_rden_i = 1'b1;
        d0 = ndone;
        start_frame(16'h0456);
        old_st = st;
        wait_t(5);  pulse_start();
        wait_t(40); pulse_start();
        wait_t(71); pulse_start();
        check("xs_cycle72", 32'(e - old_st), 32'd72);
        check("xs_cs72",    32'(bus.adc_cs_n_o), 32'd1);
        check("xs_done_n",  32'(ndone - d0), 32'd1);
        adc_word = 16'h0789;
        pulse_start();
        check("xs_cs73",    32'(bus.adc_cs_n_o), 32'd0);
        check("xs_busy73",  32'(bus.busy_o), 32'd1);
        wait_t(T + 1);
        check("xs_sample",  32'(bus.sample_o), 32'h789);

        // reset mid-SHIFT
        d0 = ndone; v0 = nvalid;
        start_frame(16'h0321);
        wait_t(30);
        rst_i = 1'b1;
        #1;
        check("rst_cs_n", 32'(bus.adc_cs_n_o), 32'd1);
        check("rst_sclk", 32'(bus.adc_sclk_o), 32'd1);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        tick(); tick();
        rst_i = 1'b0;
        repeat (3) tick();
        check("rst_no_done",  32'(ndone - d0), 32'd0);
        check("rst_no_valid", 32'(nvalid - v0), 32'd0);
        check("rst_err_clr",  32'(bus.frame_err_o), 32'd0);
        start_frame(16'h0ABC);
        wait_t(T + 1);
        check("rst_after_sample", 32'(bus.sample_o), 32'hABC);

        // randomized frames with spurious starts
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom);
            if ($urandom_range(3) != 0) w[15:12] = 4'd0;
            bus.spi_rden_i = ($urandom_range(3) != 0);
            repeat ($urandom_range(0, 4)) tick();
            start_frame(w);
            for (int n = 0; n < 200 && (e - st) < T + 1; n++) begin
                bus.spi_start_i = ($urandom_range(15) == 0) && ((e - st) <= T);
                tick();
            end
            bus.spi_start_i = 1'b0;
            check("rand_frame_end", 32'(e - st), 32'(T + 1));
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ad7476_spi_rx.md
# ad7476_spi_rx

Serial capture engine for the AD7476 12-bit ADC. It generates chip-select and serial clock, shifts in one 16-bit conversion frame, and returns the 12-bit result. It sits directly downstream of the ADC top-level sequencing FSM: it consumes that FSM's one-cycle start pulse and held read-enable, and answers with a one-cycle transfer-done pulse. The captured sample goes on to the sample FIFO/writer.

## Interface
Parameters:
- CLK_DIV, 2: SCLK half-period in clk_i cycles; legal values are 2 to 255.
- QUIET_CYCLES, 4: CS_n-high quiet time after a frame, in clk_i cycles, before done; legal values are 1 to 255.

Ports:
- clk_i  input  1  system clock; the single clock domain.
- rst_i  input  1  reset; asynchronous, active-high.
- spi_start_i  input  1  one-cycle start request from the sequencing FSM.
- spi_rden_i  input  1  read enable, held high by the FSM for the whole transfer.
- spi_tfer_done_o  output  1  one-cycle pulse at end of frame.
- busy_o  output  1  high whenever state is not IDLE.
- adc_cs_n_o  output  1  ADC chip select, active-low.
- adc_sclk_o  output  1  ADC serial clock; idles high.
- adc_sdata_i  input  1  ADC serial data.
- sample_o  output  12  last captured conversion result.
- sample_valid_o  output  1  one-cycle pulse when sample_o updates.
- frame_err_o  output  1  sticky flag: leading zeros of a frame were not all 0.

## Operation
- Reset values: adc_cs_n_o=1, adc_sclk_o=1, spi_tfer_done_o=0, busy_o=0, sample_o=0, sample_valid_o=0, frame_err_o=0, state=IDLE.
- All outputs are driven from registers.
- adc_sdata_i passes through one input register (sdata_r) before use.
- States:
  - IDLE
  - SETUP: CLK_DIV cycles with CS_n low and SCLK high.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - QUIET: QUIET_CYCLES cycles with CS_n high.
  - DONE: 1 cycle.
- IDLE→SETUP occurs when spi_start_i=1; adc_cs_n_o goes low in the same transition.
- spi_start_i is ignored in every state other than IDLE.
- In SHIFT, SCLK goes low on entry and at each period boundary.
- Capture rule: on the clk_i cycle in which adc_sclk_o rises, shift sdata_r into bit 0 of a 16-bit shift register (MSB first).
- A 5-bit bit counter counts the 16 rising edges.
- After the high phase of the 16th period, adc_cs_n_o goes high (SCLK stays high) and the block enters QUIET.
- QUIET→DONE, then DONE→IDLE.
- In DONE:
  - spi_tfer_done_o=1 for that one cycle.
  - If spi_rden_i=1, then sample_o <= shift[11:0] and sample_valid_o=1 for the same cycle.
  - If spi_rden_i=0, sample_o holds its value, no valid pulse is produced, and done still pulses.
  - If shift[15:12]!=0, frame_err_o <= 1. It stays set until rst_i; sample_o is still updated.
- Reset mid-transfer: everything returns to reset values immediately. No done or valid pulse is produced.

## Timing
- Number cycles from the edge where spi_start_i=1 is sampled (cycle 0):
  - adc_cs_n_o is low from cycle 1 to cycle 33·CLK_DIV inclusive.
  - The first SCLK fall is at cycle CLK_DIV+1.
  - The k-th SCLK rise (k=1..16) is at cycle CLK_DIV+(2k−1)·CLK_DIV+1.
  - adc_cs_n_o goes high at cycle 33·CLK_DIV+1.
  - spi_tfer_done_o and sample_valid_o are high in cycle 33·CLK_DIV+QUIET_CYCLES+1. With defaults, that is cycle 71.
- SCLK duty is exactly 50%, with period 2·CLK_DIV cycles.
- sdata_r is sampled at least CLK_DIV−1 cycles after the preceding SCLK fall.
- The earliest next start is accepted the cycle after DONE, while back in IDLE. The sequencing FSM's restart path, in which a start arrives 2 cycles after done, is therefore never dropped.
- A start arriving in the DONE cycle itself is dropped.

## Test plan
- Reset, then idle 10 cycles: cs_n=1, sclk=1, done=0, sample_o=0, busy_o=0.
- Defaults, ADC model serving frame 0x0A5C, rden=1:
  - Exactly 16 SCLK rises, each with period 4.
  - done and valid pulse together at cycle 71.
  - sample_o=0xA5C, frame_err_o=0.
- Frame 0x8FFF with rden=1: sample_o=0xFFF, frame_err_o=1. The next clean frame 0x0001 gives sample_o=0x001 with frame_err_o still 1.
- rden=0 throughout a frame 0x0123:
  - done pulses at cycle 71.
  - No valid pulse; sample_o keeps its previous value.
- Extra spi_start_i pulses at cycles 5, 40 and 71 (the DONE cycle): all are ignored, with a single frame and a single done pulse. A start at cycle 72 begins a new frame with cs_n low at 73.
- rst_i asserted at cycle 30 mid-SHIFT:
  - cs_n and sclk return high asynchronously; no done or valid pulse.
  - After release, a new start completes a normal frame.
